// File: rtl/sysid_checker_if.sv
// Bus between the sysid checker (master) and the downstream sysid slave.
// The slave returns combinational, zero-wait read data for the selected word.
interface sysid_checker_if;
    logic        sysid_address;
    logic [31:0] sysid_readdata;

    modport master (output sysid_address, input  sysid_readdata);
    modport slave  (input  sysid_address, output sysid_readdata);
endinterface

// File: rtl/sysid_checker.sv
// System-ID checker: reads the ID word (address 0) and, optionally, the
// timestamp word (address 1) from a sysid slave, compares them with the
// expected constants and reports pass/fail plus a saturating fail count.
// Optional feature macro: SYSID_CHECKER_TIMESTAMP_EN adds the timestamp
// read state and timestamp compare; without it only the ID is checked.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd452,
    parameter logic [31:0] EXPECTED_TS    = 32'd1301991580,
    parameter int unsigned RECHECK_CYCLES = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_checker_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   id_ok,
    output logic                   id_fail,
    output logic [31:0]            captured_id,
    output logic [31:0]            captured_ts,
    output logic [7:0]             mismatch_count
);

`ifdef SYSID_CHECKER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ID   = 3'd1;
    localparam logic [2:0] S_RD_TS   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] captured_id_q, captured_id_d;
    logic [31:0] captured_ts_q, captured_ts_d;
    logic        id_ok_q, id_ok_d;
    logic        id_fail_q, id_fail_d;
    logic [7:0]  mismatch_count_q, mismatch_count_d;
    logic [31:0] dwell_q, dwell_d;
    // Registered dwell-expiry flag keeps the 32-bit comparator off the
    // next-state path; the DONE dwell therefore lasts RECHECK_CYCLES+1 cycles.
    logic        expire_q, expire_d;
    logic        match;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Pass when the ID (and, if enabled, the timestamp) equal the expected words
    always_comb begin
        match = (captured_id_q == EXPECTED_ID) &&
                (!TS_EN || (captured_ts_q == EXPECTED_TS));
    end

    // Next-state, capture, compare and dwell-timer logic
    always_comb begin
        state_d          = state_q;
        captured_id_d    = captured_id_q;
        captured_ts_d    = captured_ts_q;
        id_ok_d          = id_ok_q;
        id_fail_d        = id_fail_q;
        mismatch_count_d = mismatch_count_q;
        dwell_d          = dwell_q;
        expire_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RD_ID;
            end
            S_RD_ID: begin
                captured_id_d = bus.sysid_readdata;
                state_d       = TS_EN ? S_RD_TS : S_COMPARE;
            end
            S_RD_TS: begin
                captured_ts_d = TS_EN ? bus.sysid_readdata : captured_ts_q;
                state_d       = S_COMPARE;
            end
            S_COMPARE: begin
                id_ok_d   = match;
                id_fail_d = !match;
                if (!match) begin
                    mismatch_count_d = sat_inc8(mismatch_count_q);
                end
                dwell_d = 32'd0;
                state_d = S_DONE;
            end
            S_DONE: begin
                // start and an expiring dwell in the same cycle launch one re-check
                if (start || expire_q) begin
                    dwell_d = 32'd0;
                    state_d = S_RD_ID;
                end else if (RECHECK_CYCLES != 0) begin
                    dwell_d  = dwell_q + 32'd1;
                    expire_d = (dwell_q == RECHECK_CYCLES - 32'd1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            captured_id_q    <= 32'd0;
            captured_ts_q    <= 32'd0;
            id_ok_q          <= 1'b0;
            id_fail_q        <= 1'b0;
            mismatch_count_q <= 8'd0;
            dwell_q          <= 32'd0;
            expire_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            captured_id_q    <= captured_id_d;
            captured_ts_q    <= captured_ts_d;
            id_ok_q          <= id_ok_d;
            id_fail_q        <= id_fail_d;
            mismatch_count_q <= mismatch_count_d;
            dwell_q          <= dwell_d;
            expire_q         <= expire_d;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.sysid_address = (state_q == S_RD_TS);
        busy              = (state_q == S_RD_ID) || (state_q == S_RD_TS) ||
                            (state_q == S_COMPARE);
        done              = (state_q == S_COMPARE);
        id_ok             = id_ok_q;
        id_fail           = id_fail_q;
        captured_id       = captured_id_q;
        captured_ts       = captured_ts_q;
        mismatch_count    = mismatch_count_q;
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Testbench for sysid_checker: directed vector table, hand-written corner
// sequences and randomized traffic against a step-count reference model.
module tb_sysid_checker;

`ifdef SYSID_CHECKER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int          L      = TS_EN ? 4 : 3;   // cycles from release to done
    localparam int          R      = 10;              // re-check dwell of instance B
    localparam int          P      = R + L;           // auto re-check done period
    localparam logic [31:0] EXP_ID = 32'd452;
    localparam logic [31:0] EXP_TS = 32'd1301991580;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a, start_a, rst_b, start_b;
    logic [31:0] id_val, ts_val;

    sysid_checker_if if_a ();
    sysid_checker_if if_b ();
    assign if_a.sysid_readdata = if_a.sysid_address ? ts_val : id_val;
    assign if_b.sysid_readdata = if_b.sysid_address ? ts_val : id_val;

    logic a_busy, a_done, a_id_ok, a_id_fail;
    logic [31:0] a_cap_id, a_cap_ts;
    logic [7:0] a_cnt;
    logic b_busy, b_done, b_id_ok, b_id_fail;
    logic [31:0] b_cap_id, b_cap_ts;
    logic [7:0] b_cnt;

    sysid_checker #(.RECHECK_CYCLES(0)) dut_a (
        .clock(clock), .reset_n(rst_a), .start(start_a), .bus(if_a),
        .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .id_fail(a_id_fail),
        .captured_id(a_cap_id), .captured_ts(a_cap_ts), .mismatch_count(a_cnt));

    sysid_checker #(.RECHECK_CYCLES(R)) dut_b (
        .clock(clock), .reset_n(rst_b), .start(start_b), .bus(if_b),
        .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .id_fail(b_id_fail),
        .captured_id(b_cap_id), .captured_ts(b_cap_ts), .mismatch_count(b_cnt));

    int checks = 0;
    int errors = 0;

    // Reference model: position within a check (0 idle, 1 ID read, 2 TS read
    // when enabled, L-1 compare, L = waiting for start) plus result values.
    int          m_pos;
    logic        m_ok, m_fail;
    logic [31:0] m_id, m_ts;
    int          m_cnt;

    logic s_a_done, s_a_busy, s_b_done;
    int   a_done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_ok = 1'b0; m_fail = 1'b0; m_id = 0; m_ts = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (!rst_a) begin
            model_reset();
        end else begin
            if (m_pos == 1) m_id = id_val;
            if (TS_EN && m_pos == 2) m_ts = ts_val;
            if (m_pos == L - 1) begin
                m_ok   = (m_id == EXP_ID) && (!TS_EN || m_ts == EXP_TS);
                m_fail = !m_ok;
                if (!m_ok && m_cnt < 255) m_cnt++;
            end
            if (m_pos < L) m_pos++;
            else if (start_a) m_pos = 1;
        end
    endtask

    // One clock cycle: compare A against the model mid-cycle, advance the model
    task automatic cycle();
        @(negedge clock);
        s_a_done = a_done; s_a_busy = a_busy; s_b_done = b_done;
        chk("a_address", 32'(if_a.sysid_address), 32'(TS_EN && m_pos == 2));
        chk("a_busy", 32'(a_busy), 32'(m_pos >= 1 && m_pos <= L - 1));
        chk("a_done", 32'(a_done), 32'(m_pos == L - 1));
        chk("a_id_ok", 32'(a_id_ok), 32'(m_ok));
        chk("a_id_fail", 32'(a_id_fail), 32'(m_fail));
        chk("a_captured_id", a_cap_id, m_id);
        chk("a_captured_ts", a_cap_ts, m_ts);
        chk("a_mismatch_count", 32'(a_cnt), 32'(m_cnt));
        chk("b_address_outside_busy", 32'(if_b.sysid_address & ~b_busy), 32'd0);
        if (a_done) a_done_cnt++;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done_a(input int limit, output int n);
        n = 0;
        do begin cycle(); n++; end while (!s_a_done && n < limit);
    endtask

    task automatic wait_done_b(input int limit, output int n);
        n = 0;
        do begin cycle(); n++; end while (!s_b_done && n < limit);
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [31:0] id;
        logic [31:0] ts;
        int          ncyc;
        int          exp_dones;
        logic        exp_ok;
        logic        exp_fail;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        tbl[0]  = '{1'b0, 1'b0, 32'd452, EXP_TS, 3, 0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 32'd452, EXP_TS, 8, 1, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 32'd453, EXP_TS, 2, 0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 32'd453, EXP_TS, 8, 1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b1, 32'd453, EXP_TS, 1, 0, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 32'd453, EXP_TS, 6, 1, 1'b0, 1'b1, 2};
        tbl[6]  = '{1'b1, 1'b1, 32'd453, EXP_TS, 1, 0, 1'b0, 1'b1, 2};
        tbl[7]  = '{1'b1, 1'b0, 32'd453, EXP_TS, 6, 1, 1'b0, 1'b1, 3};
        tbl[8]  = '{1'b1, 1'b1, 32'd453, EXP_TS, 1, 0, 1'b0, 1'b1, 3};
        tbl[9]  = '{1'b1, 1'b0, 32'd453, EXP_TS, 6, 1, 1'b0, 1'b1, 4};
        tbl[10] = '{1'b1, 1'b1, 32'd452, EXP_TS, 1, 0, 1'b0, 1'b1, 4};
        tbl[11] = '{1'b1, 1'b0, 32'd452, EXP_TS, 6, 1, 1'b1, 1'b0, 4};
        tbl[12] = '{1'b1, 1'b0, 32'd452, EXP_TS, 10, 0, 1'b1, 1'b0, 4};

        rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0; start_b = 1'b0;
        id_val = EXP_ID; ts_val = EXP_TS; a_done_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            rst_a = tbl[i].rst_n; start_a = tbl[i].start;
            id_val = tbl[i].id; ts_val = tbl[i].ts;
            a_done_cnt = 0;
            repeat (tbl[i].ncyc) cycle();
            start_a = 1'b0;
            chk($sformatf("vec%0d_dones", i), 32'(a_done_cnt), 32'(tbl[i].exp_dones));
            chk($sformatf("vec%0d_id_ok", i), 32'(a_id_ok), 32'(tbl[i].exp_ok));
            chk($sformatf("vec%0d_id_fail", i), 32'(a_id_fail), 32'(tbl[i].exp_fail));
            chk($sformatf("vec%0d_count", i), 32'(a_cnt), 32'(tbl[i].exp_cnt));
        end

        // Latency from reset release and pass result
        rst_a = 1'b0; id_val = EXP_ID; ts_val = TS_EN ? EXP_TS : 32'd0;
        cycle(); cycle();
        rst_a = 1'b1;
        wait_done_a(20, n);
        chk("release_to_done_latency", 32'(n), 32'(L));
        chk("pass_id_ok", 32'(a_id_ok), 32'd1);
        chk("pass_id_fail", 32'(a_id_fail), 32'd0);
        chk("pass_captured_ts", a_cap_ts, TS_EN ? EXP_TS : 32'd0);
        chk("pass_count", 32'(a_cnt), 32'd0);

        // start while busy is ignored and not queued
        start_a = 1'b1; cycle(); start_a = 1'b0;
        a_done_cnt = 0;
        cycle();
        start_a = 1'b1; cycle(); start_a = 1'b0;
        chk("ignored_start_while_busy", 32'(s_a_busy), 32'd1);
        repeat (10) cycle();
        chk("single_done_after_busy_start", 32'(a_done_cnt), 32'd1);

        // Reset in the middle of a check aborts it
        start_a = 1'b1; cycle(); start_a = 1'b0;
        a_done_cnt = 0;
        if (TS_EN) cycle();
        rst_a = 1'b0;
        cycle();
        chk("reset_hit_while_busy", 32'(s_a_busy), 32'd1);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_id_ok", 32'(a_id_ok), 32'd0);
        chk("abort_id_fail", 32'(a_id_fail), 32'd0);
        chk("abort_captured_id", a_cap_id, 32'd0);
        chk("abort_captured_ts", a_cap_ts, 32'd0);
        chk("abort_count", 32'(a_cnt), 32'd0);
        chk("abort_address", 32'(if_a.sysid_address), 32'd0);
        cycle();
        chk("abort_no_done", 32'(a_done_cnt), 32'd0);
        rst_a = 1'b1;
        wait_done_a(20, n);
        chk("restart_latency", 32'(n), 32'(L));

        // Mismatch counter saturates at 255
        id_val = 32'd453;
        repeat (258) begin
            start_a = 1'b1; cycle(); start_a = 1'b0;
            repeat (L) cycle();
        end
        chk("count_saturated", 32'(a_cnt), 32'd255);
        chk("saturated_id_fail", 32'(a_id_fail), 32'd1);

        // Automatic re-check period and start around the dwell expiry (instance B)
        id_val = EXP_ID; ts_val = EXP_TS;
        rst_b = 1'b1;
        wait_done_b(40, n);
        chk("b_first_latency", 32'(n), 32'(L));
        wait_done_b(60, n);
        chk("b_recheck_period", 32'(n), 32'(P));
        repeat (R - 1) cycle();
        start_b = 1'b1; cycle(); start_b = 1'b0;
        wait_done_b(60, n);
        chk("b_start_before_expiry_period", 32'(n + R), 32'(P - 1));
        repeat (R) cycle();
        start_b = 1'b1; cycle(); start_b = 1'b0;
        wait_done_b(60, n);
        chk("b_start_on_expiry_period", 32'(n + R + 1), 32'(P));
        wait_done_b(60, n);
        chk("b_period_after_expiry_start", 32'(n), 32'(P));
        chk("b_id_ok", 32'(b_id_ok), 32'd1);
        chk("b_id_fail", 32'(b_id_fail), 32'd0);
        chk("b_captured_id", b_cap_id, EXP_ID);
        chk("b_captured_ts", b_cap_ts, TS_EN ? EXP_TS : 32'd0);
        chk("b_count", 32'(b_cnt), 32'd0);

        // Randomized traffic on instance A against the model
        for (int k = 0; k < 600; k++) begin
            rst_a   = ($urandom_range(0, 40) != 0);
            start_a = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: id_val = EXP_ID;
                1: id_val = EXP_ID + 32'd1;
                default: id_val = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0: ts_val = EXP_TS;
                1: ts_val = 32'd0;
                default: ts_val = $urandom;
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
